ca_sched: RTL and testbench

- Scheduler and memory-write arbiter for the cellular-automaton row generator.
- After reset, seeds half 0 of the 160-word row memory.
- Triggers one generation per TICK_DIV frame ticks (or per manual step while paused), holding the generator's direction constant for the whole run.
- Owns the memory write port and tells the display side which half (0 = words 0..79, 1 = words 80..159) holds the current row.

---
 rtl/ca_sched.sv | 103 ++++++++++
 tb/tb_ca_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ca_sched.sv
// ca_sched: generation scheduler and row-memory write arbiter for the CA row generator.
// Seeds half 0 after reset, then runs one generation per trigger and flips the display half.
module ca_sched #(
    parameter int          WORDS      = 80,
    parameter int          GEN_CYCLES = 86,
    parameter int          TICK_DIV   = 1,
    parameter int          SEED_WORD  = 40,
    parameter logic [15:0] SEED_VALUE = 16'h8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        step_req,
    input  logic        frame_tick,
    output logic        gen_start,
    output logic        gen_dir,
    input  logic        gen_write,
    input  logic [7:0]  gen_waddr,
    input  logic [15:0] gen_wdata,
    output logic        mem_write,
    output logic [7:0]  mem_waddr,
    output logic [15:0] mem_wdata,
    output logic        disp_half,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] gen_count
);
    localparam logic [2:0]  INIT   = 3'd0;
    localparam logic [2:0]  IDLE   = 3'd1;
    localparam logic [2:0]  START  = 3'd2;
    localparam logic [2:0]  RUN    = 3'd3;
    localparam logic [2:0]  SWAP   = 3'd4;
    localparam logic [7:0]  LAST_W = 8'(WORDS - 1);
    localparam logic [7:0]  SEED_A = 8'(SEED_WORD);
    localparam logic [15:0] LAST_T = 16'(TICK_DIV - 1);
    localparam logic [15:0] RUN_LD = 16'(GEN_CYCLES - 1);

    logic [2:0]  state;
    logic [7:0]  init_addr;
    logic [15:0] tick_cnt;
    logic [15:0] run_cnt;
    logic        tick_ok;
    logic        tick_last;
    logic        trig;

    always_comb begin
        tick_ok   = enable && frame_tick;
        tick_last = tick_cnt == LAST_T;
        trig      = enable ? tick_ok && tick_last : step_req;
        busy      = state != IDLE;
        gen_dir   = disp_half;
        // generator writes reach memory only while a run is in progress
        mem_write = state == INIT || (state == RUN && gen_write);
        mem_waddr = state == RUN ? gen_waddr : state == INIT ? init_addr : 8'd0;
        mem_wdata = state == RUN ? gen_wdata :
                    (state == INIT && init_addr == SEED_A) ? SEED_VALUE : 16'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            init_addr <= 8'd0;
            tick_cnt  <= 16'd0;
            run_cnt   <= 16'd0;
            gen_start <= 1'b0;
            disp_half <= 1'b0;
            overrun   <= 1'b0;
            gen_count <= 16'd0;
        end else begin
            gen_start <= state == IDLE && trig;
            if (tick_ok && state != IDLE && state != INIT)
                overrun <= 1'b1;
            case (state)
                INIT: begin
                    init_addr <= init_addr + 8'd1;
                    if (init_addr == LAST_W)
                        state <= IDLE;
                end
                IDLE: begin
                    if (tick_ok)
                        tick_cnt <= tick_last ? 16'd0 : tick_cnt + 16'd1;
                    if (trig)
                        state <= START;
                end
                START: begin
                    run_cnt <= RUN_LD;
                    state   <= RUN;
                end
                RUN: begin
                    run_cnt <= run_cnt - 16'd1;
                    if (run_cnt == 16'd0)
                        state <= SWAP;
                end
                SWAP: begin
                    disp_half <= ~disp_half;
                    gen_count <= gen_count + 16'd1;
                    state     <= IDLE;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_ca_sched.sv
// tb_ca_sched: vector table, timeline reference model under random stimulus, and a
// hand sequence for the frame divider; two DUTs (TICK_DIV 1 and 3) share all inputs.
module tb_ca_sched;
    localparam int          G  = 86;
    localparam int          W  = 80;
    localparam int          SW = 40;
    localparam logic [15:0] SV = 16'h8000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        step_req = 1'b0;
    logic        frame_tick = 1'b0;
    logic        gen_write = 1'b0;
    logic [7:0]  gen_waddr = 8'd0;
    logic [15:0] gen_wdata = 16'd0;
    logic [1:0]  gs, gd, mw, dh, bz, ov;
    logic [7:0]  wa [2];
    logic [15:0] wd [2];
    logic [15:0] gc [2];

    always #5 clk = ~clk;

    ca_sched #(.TICK_DIV(1)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .step_req(step_req), .frame_tick(frame_tick),
        .gen_start(gs[0]), .gen_dir(gd[0]), .gen_write(gen_write), .gen_waddr(gen_waddr),
        .gen_wdata(gen_wdata), .mem_write(mw[0]), .mem_waddr(wa[0]), .mem_wdata(wd[0]),
        .disp_half(dh[0]), .busy(bz[0]), .overrun(ov[0]), .gen_count(gc[0])
    );
    ca_sched #(.TICK_DIV(3)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .step_req(step_req), .frame_tick(frame_tick),
        .gen_start(gs[1]), .gen_dir(gd[1]), .gen_write(gen_write), .gen_waddr(gen_waddr),
        .gen_wdata(gen_wdata), .mem_write(mw[1]), .mem_waddr(wa[1]), .mem_wdata(wd[1]),
        .disp_half(dh[1]), .busy(bz[1]), .overrun(ov[1]), .gen_count(gc[1])
    );

    // model: phase 0 = seeding, 1 = idle, 2 = one generation timeline of G+2 cycles
    int ph [2];
    int age [2];
    int tk [2];
    int cnt [2];
    bit hf [2];
    bit ovm [2];
    int td [2] = '{1, 3};
    bit valid = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        bit r, en, st, tk;
        int n;
        bit busy, half;
        int cnt;
        bit ovr;
    } vec_t;
    vec_t vt [15];

    task automatic chk(input string n, input int i, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h expected %0h", n, i, a, e);
        end
    endtask

    task automatic rnd_gen();
        gen_write = 1'($urandom_range(0, 1));
        gen_waddr = 8'($urandom);
        gen_wdata = 16'($urandom);
    endtask

    task automatic cyc();
        #1;
        if (valid) for (int i = 0; i < 2; i++) begin
            bit run;
            bit ew;
            run = ph[i] == 2 && age[i] >= 1 && age[i] <= G;
            ew  = ph[i] == 0 || (run && gen_write);
            chk("busy", i, bz[i], ph[i] != 1);
            chk("gen_start", i, gs[i], ph[i] == 2 && age[i] == 0);
            chk("mem_write", i, mw[i], ew);
            if (ew) begin
                chk("mem_waddr", i, wa[i], ph[i] == 0 ? age[i] : int'(gen_waddr));
                chk("mem_wdata", i, wd[i], ph[i] == 0 ? (age[i] == SW ? int'(SV) : 0) : int'(gen_wdata));
            end
            chk("disp_half", i, dh[i], hf[i]);
            chk("gen_dir", i, gd[i], hf[i]);
            chk("overrun", i, ov[i], ovm[i]);
            chk("gen_count", i, gc[i], cnt[i]);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ph[i] = 0; age[i] = 0; tk[i] = 0; cnt[i] = 0; hf[i] = 0; ovm[i] = 0;
            end else if (ph[i] == 0) begin
                age[i]++;
                if (age[i] == W) begin ph[i] = 1; age[i] = 0; end
            end else if (ph[i] == 1) begin
                bit trig;
                trig = enable ? (frame_tick && tk[i] == td[i] - 1) : step_req;
                if (enable && frame_tick) tk[i] = (tk[i] == td[i] - 1) ? 0 : tk[i] + 1;
                if (trig) begin ph[i] = 2; age[i] = 0; end
            end else begin
                if (enable && frame_tick) ovm[i] = 1;
                age[i]++;
                if (age[i] == G + 2) begin
                    ph[i] = 1; age[i] = 0; hf[i] = !hf[i]; cnt[i] = (cnt[i] + 1) & 16'hFFFF;
                end
            end
        end
        if (rst) valid = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int starts;
        vt[0]  = '{1, 0, 0, 0,  1, 1, 0, 0, 0};
        vt[1]  = '{0, 0, 0, 0, 80, 0, 0, 0, 0};
        vt[2]  = '{0, 1, 0, 1,  1, 1, 0, 0, 0};
        vt[3]  = '{0, 1, 0, 0, 87, 1, 0, 0, 0};
        vt[4]  = '{0, 1, 0, 0,  1, 0, 1, 1, 0};
        vt[5]  = '{0, 1, 0, 1,  2, 1, 1, 1, 0};
        vt[6]  = '{0, 1, 0, 1,  1, 1, 1, 1, 1};
        vt[7]  = '{0, 0, 1, 0,  1, 1, 1, 1, 1};
        vt[8]  = '{0, 0, 0, 0, 86, 0, 0, 2, 1};
        vt[9]  = '{0, 0, 0, 1,  3, 0, 0, 2, 1};
        vt[10] = '{0, 0, 1, 0, 89, 0, 1, 3, 1};
        vt[11] = '{0, 1, 1, 1,  1, 1, 1, 3, 1};
        vt[12] = '{0, 1, 0, 0, 40, 1, 1, 3, 1};
        vt[13] = '{1, 1, 0, 0,  1, 1, 0, 0, 0};
        vt[14] = '{0, 0, 0, 0, 80, 0, 0, 0, 0};
        @(negedge clk);
        cyc();
        cyc();
        for (int v = 0; v < 15; v++) begin
            rst = vt[v].r; enable = vt[v].en; step_req = vt[v].st; frame_tick = vt[v].tk;
            rnd_gen();
            cyc();
            rst = 1'b0; step_req = 1'b0; frame_tick = 1'b0;
            repeat (vt[v].n - 1) begin rnd_gen(); cyc(); end
            #1;
            chk($sformatf("vec%0d.busy", v), 0, bz[0], vt[v].busy);
            chk($sformatf("vec%0d.disp_half", v), 0, dh[0], vt[v].half);
            chk($sformatf("vec%0d.gen_count", v), 0, gc[0], vt[v].cnt);
            chk($sformatf("vec%0d.overrun", v), 0, ov[0], vt[v].ovr);
        end
        for (int c = 0; c < 4000; c++) begin
            rst = $urandom_range(0, 599) == 0;
            if ($urandom_range(0, 199) == 0) enable = !enable;
            frame_tick = $urandom_range(0, 24) == 0;
            step_req = $urandom_range(0, 24) == 0;
            rnd_gen();
            cyc();
        end
        rst = 1'b1; frame_tick = 1'b0; step_req = 1'b0; gen_write = 1'b0;
        cyc();
        rst = 1'b0; enable = 1'b1;
        repeat (85) cyc();
        for (int k = 1; k <= 7; k++) begin
            starts = 0;
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            if (gs[1]) starts++;
            repeat (199) begin
                cyc();
                if (gs[1]) starts++;
            end
            chk($sformatf("div3.starts_after_tick%0d", k), 1, starts, k % 3 == 0);
        end
        chk("div3.gen_count", 1, gc[1], 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
